text_mem_loader: RTL and testbench

//  Write-side counterpart of the instruction ROM. Takes a byte stream (e.g. from UART RX), checks a framed image,

---
 rtl/text_mem_loader.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_text_mem_loader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_mem_loader.sv
// -----------------------------------------------------------------------------
// text_mem_loader
//
// Purpose:
//   Write-side counterpart of the instruction ROM. Takes a byte stream (for
//   example from a UART receiver) and checks a framed program image. It
//   assembles little-endian 32-bit words and drives the text-memory write port.
//   The core is held in reset while an image is being loaded.
//
//   Frame layout:
//     SYNC_BYTE, LEN_LO, LEN_HI, 4*N data bytes, CSUM
//   N is a 16-bit word count. CSUM is the 8-bit sum (mod 256) of the data bytes.
//
// Ports:
//   clk         in   1           system clock
//   rst_n       in   1           asynchronous active-low reset
//   rx_data     in   8           received byte, valid when rx_valid=1
//   rx_valid    in   1           one-cycle strobe per byte, always accepted
//   w_en        out  1           text-memory write enable, one pulse per word
//   w_addr      out  ADDR_WIDTH  word address of the write
//   w_data      out  32          word to write
//   core_rst_n  out  1           core reset hold (0 = core held in reset)
//   busy        out  1           frame in progress (LEN_LO..CSUM)
//   done        out  1           last frame loaded, checksum matched (sticky)
//   err         out  1           last frame failed (sticky)
//   err_code    out  2           01 checksum, 10 length overflow, 11 timeout
// -----------------------------------------------------------------------------
module text_mem_loader #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0800,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [31:0]           w_data,
  output logic                  core_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);

  // Word index of the first loaded word, and how many words fit above it.
  localparam logic [31:0] MEM_WORDS   = 32'd1 << ADDR_WIDTH;
  localparam logic [31:0] BASE_WORD_W = {2'b00, BASE_ADDR[31:2]} & (MEM_WORDS - 32'd1);
  localparam logic [31:0] AVAIL_WORDS = MEM_WORDS - BASE_WORD_W;
  localparam logic [ADDR_WIDTH-1:0] BASE_WORD = BASE_WORD_W[ADDR_WIDTH-1:0];

  // Timeout fires when the idle counter would step from TO_LAST to TIMEOUT_CYC.
  localparam bit          TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [31:0] TO_LAST = TIMEOUT_CYC - 32'd1;

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_CSUM  = 2'b01;
  localparam logic [1:0] CODE_LEN   = 2'b10;
  localparam logic [1:0] CODE_TOUT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [1:0]              err_code_r;
  logic [1:0]              err_code_nxt_s;

  logic [15:0]             len_r;
  logic [15:0]             word_cnt_r;
  logic [1:0]              byte_cnt_r;
  logic [7:0]              csum_r;
  logic [23:0]             asm_r;
  logic [31:0]             idle_cnt_r;

  logic                    w_en_r;
  logic [ADDR_WIDTH-1:0]   w_addr_r;
  logic [31:0]             w_data_r;
  logic                    core_rst_n_r;

  logic [15:0]             len_full_s;
  logic                    in_frame_s;
  logic                    timeout_s;
  logic                    last_byte_s;
  logic                    last_word_s;
  logic                    enter_len_lo_s;
  logic                    busy_s;
  logic                    done_s;
  logic                    err_s;
  logic                    core_run_s;

  // Decode helpers shared by the next-state logic and the datapath.
  always_comb begin
    len_full_s     = {rx_data, len_r[7:0]};
    in_frame_s     = (state_r == S_LEN_LO) || (state_r == S_LEN_HI) ||
                     (state_r == S_DATA)   || (state_r == S_CSUM);
    // A byte arriving on the expiry cycle wins over the timeout.
    timeout_s      = TO_EN && in_frame_s && !rx_valid && (idle_cnt_r == TO_LAST);
    last_byte_s    = (byte_cnt_r == 2'd3);
    last_word_s    = ((word_cnt_r + 16'd1) == len_r);
    enter_len_lo_s = (state_r != S_LEN_LO) && (state_nxt_s == S_LEN_LO);
  end

  // State register together with the error code it carries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      err_code_r <= CODE_NONE;
    end else begin
      state_r    <= state_nxt_s;
      err_code_r <= err_code_nxt_s;
    end
  end

  // Next-state logic: frame parsing, length/checksum checks and timeout.
  always_comb begin
    state_nxt_s    = state_r;
    err_code_nxt_s = err_code_r;
    case (state_r)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_nxt_s = S_LEN_LO;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_LEN_LO: begin
        if (rx_valid) begin
          state_nxt_s = S_LEN_HI;
        end else if (timeout_s) begin
          state_nxt_s    = S_ERROR;
          err_code_nxt_s = CODE_TOUT;
        end else begin
          state_nxt_s = S_LEN_LO;
        end
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          // Widened compare so the limit can equal 2**16 words.
          if ({16'd0, len_full_s} > AVAIL_WORDS) begin
            state_nxt_s    = S_ERROR;
            err_code_nxt_s = CODE_LEN;
          end else if (len_full_s == 16'd0) begin
            state_nxt_s = S_CSUM;
          end else begin
            state_nxt_s = S_DATA;
          end
        end else if (timeout_s) begin
          state_nxt_s    = S_ERROR;
          err_code_nxt_s = CODE_TOUT;
        end else begin
          state_nxt_s = S_LEN_HI;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          if (last_byte_s && last_word_s) begin
            state_nxt_s = S_CSUM;
          end else begin
            state_nxt_s = S_DATA;
          end
        end else if (timeout_s) begin
          state_nxt_s    = S_ERROR;
          err_code_nxt_s = CODE_TOUT;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum_r) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s    = S_ERROR;
            err_code_nxt_s = CODE_CSUM;
          end
        end else if (timeout_s) begin
          state_nxt_s    = S_ERROR;
          err_code_nxt_s = CODE_TOUT;
        end else begin
          state_nxt_s = S_CSUM;
        end
      end
      S_DONE, S_ERROR: begin
        // Sticky until a new frame starts; the restart clears the code.
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_nxt_s    = S_LEN_LO;
          err_code_nxt_s = CODE_NONE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s    = S_IDLE;
        err_code_nxt_s = CODE_NONE;
      end
    endcase
  end

  // Output decode of the current state.
  always_comb begin
    busy_s     = 1'b0;
    done_s     = 1'b0;
    err_s      = 1'b0;
    core_run_s = 1'b0;
    case (state_r)
      S_IDLE:   core_run_s = 1'b1;
      S_LEN_LO: busy_s     = 1'b1;
      S_LEN_HI: busy_s     = 1'b1;
      S_DATA:   busy_s     = 1'b1;
      S_CSUM:   busy_s     = 1'b1;
      S_DONE: begin
        done_s     = 1'b1;
        core_run_s = 1'b1;
      end
      S_ERROR:  err_s      = 1'b1;
      default: begin
        busy_s     = 1'b0;
        core_run_s = 1'b1;
      end
    endcase
  end

  // Length latch, byte/word counters, checksum and word assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r      <= 16'd0;
      word_cnt_r <= 16'd0;
      byte_cnt_r <= 2'd0;
      csum_r     <= 8'd0;
      asm_r      <= 24'd0;
    end else if (enter_len_lo_s) begin
      word_cnt_r <= 16'd0;
      byte_cnt_r <= 2'd0;
      csum_r     <= 8'd0;
    end else if (rx_valid) begin
      case (state_r)
        S_LEN_LO: len_r[7:0]  <= rx_data;
        S_LEN_HI: len_r[15:8] <= rx_data;
        S_DATA: begin
          csum_r     <= csum_r + rx_data;
          byte_cnt_r <= byte_cnt_r + 2'd1;
          case (byte_cnt_r)
            2'd0:    asm_r[7:0]   <= rx_data;
            2'd1:    asm_r[15:8]  <= rx_data;
            2'd2:    asm_r[23:16] <= rx_data;
            // Fourth byte goes straight to the write port.
            default: word_cnt_r   <= word_cnt_r + 16'd1;
          endcase
        end
        default: begin
          len_r <= len_r;
        end
      endcase
    end else begin
      len_r <= len_r;
    end
  end

  // Idle-cycle counter for the inter-byte timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_r <= 32'd0;
    end else if (!in_frame_s || rx_valid) begin
      idle_cnt_r <= 32'd0;
    end else if (TO_EN) begin
      idle_cnt_r <= idle_cnt_r + 32'd1;
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end

  // Text-memory write port: address/data hold their last values between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en_r   <= 1'b0;
      w_addr_r <= '0;
      w_data_r <= 32'd0;
    end else if ((state_r == S_DATA) && rx_valid && last_byte_s) begin
      w_en_r   <= 1'b1;
      w_addr_r <= BASE_WORD + word_cnt_r[ADDR_WIDTH-1:0];
      w_data_r <= {rx_data, asm_r};
    end else begin
      w_en_r   <= 1'b0;
    end
  end

  // Core reset hold follows the state one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rst_n_r <= 1'b1;
    end else begin
      core_rst_n_r <= core_run_s;
    end
  end

  assign w_en       = w_en_r;
  assign w_addr     = w_addr_r;
  assign w_data     = w_data_r;
  assign core_rst_n = core_rst_n_r;
  assign busy       = busy_s;
  assign done       = done_s;
  assign err        = err_s;
  assign err_code   = err_code_r;

endmodule

// File: tb/tb_text_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_text_mem_loader
//
// Self-checking bench for text_mem_loader. Whole frames are modelled
// arithmetically from their byte list. The model gives the expected write
// sequence and the final status, which are compared with the writes captured
// from the DUT and with its sticky status outputs.
// -----------------------------------------------------------------------------
module tb_text_mem_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        w_en;
  logic [11:0] w_addr;
  logic [31:0] w_data;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  logic [43:0] obs_q[$];
  logic [43:0] exp_q[$];
  logic        exp_done;
  logic [1:0]  exp_code;
  logic [7:0]  fr[$];

  text_mem_loader #(
    .ADDR_WIDTH (12),
    .BASE_ADDR  (32'h0000_0800),
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .core_rst_n(core_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every write pulse away from the active edge.
  always @(negedge clk) begin
    if (w_en === 1'b1) obs_q.push_back({w_addr, w_data});
  end

  // Caller must be at a negedge; gap=0 gives back-to-back bytes.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int maxgap);
    foreach (f[i]) send_byte(f[i], $urandom_range(0, maxgap));
  endtask

  // Reference: frame bytes -> expected writes and final status.
  task automatic model_frame(input logic [7:0] f[$]);
    int n;
    logic [7:0] s;
    exp_q.delete();
    n = {f[2], f[1]};
    s = 8'd0;
    if (n > 'hE00) begin
      exp_done = 1'b0;
      exp_code = 2'b10;
    end else begin
      for (int w = 0; w < n; w++)
        exp_q.push_back({12'h200 + 12'(w), f[6+4*w], f[5+4*w], f[4+4*w], f[3+4*w]});
      for (int k = 0; k < 4*n; k++) s = s + f[3+k];
      exp_done = (f[3+4*n] == s);
      exp_code = exp_done ? 2'b00 : 2'b01;
    end
  endtask

  task automatic load_frame1();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h15, 8'h00,
           8'h93, 8'h05, 8'h00, 8'h00, 8'hC5};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({w_en, w_addr, w_data, core_rst_n, busy, done, err, err_code} !==
        {1'b0, 12'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL reset_values: got en=%b a=%h d=%h crst=%b busy=%b done=%b err=%b code=%b exp 0 000 00000000 1 0 0 0 00",
               w_en, w_addr, w_data, core_rst_n, busy, done, err, err_code);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    load_frame1(); model_frame(fr); obs_q.delete();
    for (int i = 0; i < 5; i++) send_byte(fr[i], $urandom_range(0, 2));
    checks++;
    if ({core_rst_n, busy} !== 2'b01) begin
      errors++; $display("FAIL good_midframe: got crst/busy=%b exp 01", {core_rst_n, busy});
    end
    for (int i = 5; i < fr.size(); i++) send_byte(fr[i], $urandom_range(0, 2));
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL good_wcount: got %0d exp 2", obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL good_word%0d: got %h exp %h", k, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if (obs_q.size() > 0 && obs_q[0] !== 44'h200_00150513) begin
      errors++; $display("FAIL good_word0_const: got %h exp 20000150513", obs_q[0]);
    end
    checks++;
    if ({w_addr, w_data} !== 44'h201_00000593) begin
      errors++; $display("FAIL good_hold: got %h exp 20100000593", {w_addr, w_data});
    end
    checks++;
    if ({done, err, err_code, core_rst_n, busy} !== {exp_done, |exp_code, exp_code, exp_done, 1'b0}) begin
      errors++; $display("FAIL good_status: got %b exp %b", {done, err, err_code, core_rst_n, busy},
                         {exp_done, |exp_code, exp_code, exp_done, 1'b0});
    end
  endtask

  task automatic test_bad_csum();
    load_frame1(); fr[11] = 8'hC4; model_frame(fr); obs_q.delete();
    send_frame(fr, 2);
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL csum_wcount: got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL csum_word%0d: got %h exp %h", k, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if ({done, err, err_code, core_rst_n} !== 5'b0_1_01_0) begin
      errors++; $display("FAIL csum_status: got %b exp 01010", {done, err, err_code, core_rst_n});
    end
  endtask

  task automatic test_len_overflow();
    fr = '{8'hA5, 8'h01, 8'h0E}; model_frame(fr); obs_q.delete();
    send_frame(fr, 1);
    repeat (3) @(negedge clk);
    checks++;
    if ({obs_q.size() == 0, done, err, err_code, core_rst_n} !== {1'b1, exp_done, |exp_code, exp_code, 1'b0}) begin
      errors++; $display("FAIL len_overflow: got nowr=%b done=%b err=%b code=%b crst=%b exp 1 0 1 10 0",
                         obs_q.size() == 0, done, err, err_code, core_rst_n);
    end
    // Exactly the available word count is accepted; the frame then times out.
    fr = '{8'hA5, 8'h00, 8'h0E}; send_frame(fr, 0);
    @(negedge clk);
    checks++;
    if ({busy, err} !== 2'b10) begin
      errors++; $display("FAIL len_max_accept: got busy/err=%b exp 10", {busy, err});
    end
    repeat (110) @(negedge clk);
    checks++;
    if ({err, err_code, obs_q.size() == 0} !== 4'b1_11_1) begin
      errors++; $display("FAIL len_max_timeout: got err=%b code=%b nowr=%b exp 1 11 1",
                         err, err_code, obs_q.size() == 0);
    end
    load_frame1(); model_frame(fr); obs_q.delete();
    send_frame(fr, 2);
    repeat (3) @(negedge clk);
    checks++;
    if ({done, err, obs_q.size() == 2} !== 3'b101) begin
      errors++; $display("FAIL len_recover: got done=%b err=%b nwr=%0d exp 1 0 2", done, err, obs_q.size());
    end
  endtask

  task automatic test_timeout();
    fr = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h05}; obs_q.delete();
    send_frame(fr, 0);
    repeat (99) @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL tout_early: got err=%b exp 0 at 99 cycles", err);
    end
    @(negedge clk);
    checks++;
    if ({err, err_code, core_rst_n, obs_q.size() == 0} !== 5'b1_11_0_1) begin
      errors++; $display("FAIL tout_expire: got err=%b code=%b crst=%b nowr=%b exp 1 11 0 1",
                         err, err_code, core_rst_n, obs_q.size() == 0);
    end
    // Byte landing on the expiry cycle is processed instead of timing out.
    send_frame(fr, 0);
    repeat (99) @(negedge clk);
    send_byte(8'h15, 0);
    checks++;
    if ({err, busy} !== 2'b01) begin
      errors++; $display("FAIL tout_byte_wins: got err/busy=%b exp 01", {err, busy});
    end
    send_byte(8'h00, 1);
    send_byte(8'h2D, 1);
    repeat (3) @(negedge clk);
    checks++;
    if ({done, err, obs_q.size() == 1} !== 3'b101 || (obs_q.size() == 1 && obs_q[0] !== 44'h200_00150513)) begin
      errors++; $display("FAIL tout_byte_frame: got done=%b err=%b nwr=%0d exp 1 0 1 word 20000150513",
                         done, err, obs_q.size());
    end
  endtask

  task automatic test_garbage();
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    fr = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h00, 8'h00}; obs_q.delete();
    for (int i = 0; i < 3; i++) send_byte(fr[i], 1);
    checks++;
    if ({busy, done, err, core_rst_n} !== 4'b0001) begin
      errors++; $display("FAIL garbage_idle: got busy/done/err/crst=%b exp 0001", {busy, done, err, core_rst_n});
    end
    for (int i = 3; i < 7; i++) send_byte(fr[i], 1);
    repeat (3) @(negedge clk);
    checks++;
    if ({done, err, err_code, obs_q.size() == 0} !== 5'b1_0_00_1) begin
      errors++; $display("FAIL garbage_zero_len: got done=%b err=%b code=%b nowr=%b exp 1 0 00 1",
                         done, err, err_code, obs_q.size() == 0);
    end
  endtask

  task automatic test_async_reset();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05}; obs_q.delete();
    send_frame(fr, 1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({w_en, w_addr, w_data, core_rst_n, busy, done, err, err_code} !==
        {1'b0, 12'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00}) begin
      errors++; $display("FAIL async_reset: got en=%b a=%h d=%h crst=%b busy=%b done=%b err=%b code=%b",
                         w_en, w_addr, w_data, core_rst_n, busy, done, err, err_code);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load_frame1(); model_frame(fr); obs_q.delete();
    send_frame(fr, 2);
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size() || done !== 1'b1) begin
      errors++; $display("FAIL async_rerun: got nwr=%0d done=%b exp %0d 1", obs_q.size(), done, exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL async_word%0d: got %h exp %h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 12; i++) begin
      int n;
      logic [7:0] s;
      logic [7:0] b;
      fr.delete();
      fr.push_back(8'hA5);
      if ($urandom_range(0, 7) == 0) n = 'hE01 + $urandom_range(0, 255);
      else n = $urandom_range(0, 6);
      fr.push_back(n[7:0]);
      fr.push_back(n[15:8]);
      if (n <= 'hE00) begin
        s = 8'd0;
        for (int k = 0; k < 4*n; k++) begin
          b = 8'($urandom);
          fr.push_back(b);
          s = s + b;
        end
        fr.push_back(($urandom_range(0, 3) == 0) ? s + 8'd1 : s);
      end
      model_frame(fr); obs_q.delete();
      send_frame(fr, 3);
      repeat (3) @(negedge clk);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand%0d_wcount: got %0d exp %0d", i, obs_q.size(), exp_q.size());
      end
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL rand%0d_word%0d: got %h exp %h", i, k, obs_q[k], exp_q[k]);
        end
      end
      checks++;
      if ({done, err, err_code, core_rst_n, busy} !== {exp_done, |exp_code, exp_code, exp_done, 1'b0}) begin
        errors++; $display("FAIL rand%0d_status: got %b exp %b", i, {done, err, err_code, core_rst_n, busy},
                           {exp_done, |exp_code, exp_code, exp_done, 1'b0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_len_overflow();
    test_timeout();
    test_garbage();
    test_async_reset();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
